host_io: RTL and testbench

HOST_IO -- requirements
Module: host_io

---
 rtl/host_io_pkg.sv | 23 ++
 rtl/host_io_fifo.sv | 50 +++++
 rtl/host_io.sv | 148 ++++++++++++++
 tb/tb_host_io.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_io_pkg.sv
// Shared constants for host_io: default bus addresses, status-word layout
// and the watchdog state encoding.
package host_io_pkg;

    localparam logic [31:0] DEFAULT_CONSOLE_ADDR       = 32'h1000_0000;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR        = 32'h1000_1000;
    localparam logic [31:0] DEFAULT_LEGACY_TOHOST_ADDR = 32'h0000_1000;

    // Status word at CONSOLE_ADDR+4: {drop_cnt, 6'b0, timeout, full, level[7:0]}
    localparam int unsigned STAT_LEVEL_LSB   = 0;
    localparam int unsigned STAT_LEVEL_W     = 8;
    localparam int unsigned STAT_FULL_BIT    = 8;
    localparam int unsigned STAT_TIMEOUT_BIT = 9;
    localparam int unsigned STAT_DROP_LSB    = 16;
    localparam int unsigned STAT_DROP_W      = 16;

    typedef enum logic [1:0] {
        WD_RUN     = 2'd0,
        WD_EXITED  = 2'd1,
        WD_EXPIRED = 2'd2
    } wd_state_t;

endpackage

// File: rtl/host_io_fifo.sv
// Console byte FIFO with wrap-around pointers; the extra pointer bit
// separates full from empty. Head entry is presented combinationally.
module host_io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push && (!full || do_pop);

    // Empty reads as zero so con_data is 0 out of reset without clearing storage.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/host_io.sv
// Simulation host I/O block: memory-mapped console FIFO, tohost exit
// register and a cycle watchdog.
module host_io
    import host_io_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR       = DEFAULT_CONSOLE_ADDR,
    parameter logic [31:0] TOHOST_ADDR        = DEFAULT_TOHOST_ADDR,
    parameter logic [31:0] LEGACY_TOHOST_ADDR = DEFAULT_LEGACY_TOHOST_ADDR,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 500_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        exit_valid,
    output logic [30:0] exit_code,
    output logic        timeout,
    output logic        halt
);

    localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] STATUS_ADDR = CONSOLE_ADDR + 32'd4;
    localparam logic [31:0] WD_LIMIT    = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

    logic            push_req;
    logic            pop;
    logic            push_ok;
    logic            fifo_empty;
    logic            fifo_full;
    logic [LW-1:0]   fifo_level;
    logic [15:0]     drop_cnt;
    logic [31:0]     tohost_q;
    logic            tohost_hit;
    logic            tohost_wr;
    logic            exit_set;
    logic            rd_req;
    logic [31:0]     status_word;
    logic [31:0]     rd_value;
    wd_state_t       wd_state;
    logic [31:0]     wd_count;
    logic            unused_bits;

    assign unused_bits = ^mem_wmask[3:1];

    assign push_req   = mem_valid && mem_write && mem_wmask[0] && (mem_addr == CONSOLE_ADDR);
    assign pop        = con_valid && con_ready;
    assign push_ok    = !fifo_full || pop;
    assign tohost_hit = (mem_addr == TOHOST_ADDR) || (mem_addr == LEGACY_TOHOST_ADDR);
    assign tohost_wr  = mem_valid && mem_write && mem_wmask[0] && tohost_hit && !exit_valid;
    assign exit_set   = tohost_wr && mem_wdata[0];
    assign rd_req     = mem_valid && !mem_write;

    assign con_valid  = !fifo_empty;
    assign halt       = exit_valid && fifo_empty;

    host_io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .wdata (mem_wdata[7:0]),
        .pop   (pop),
        .rdata (con_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = 8'(fifo_level);
        status_word[STAT_FULL_BIT]                  = fifo_full;
        status_word[STAT_TIMEOUT_BIT]               = timeout;
        status_word[STAT_DROP_LSB +: STAT_DROP_W]   = drop_cnt;
    end

    always_comb begin
        rd_value = '0;
        if (mem_addr == STATUS_ADDR) rd_value = status_word;
        else if (tohost_hit)         rd_value = tohost_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (push_req && !push_ok && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tohost_q   <= '0;
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else if (tohost_wr) begin
            tohost_q <= mem_wdata;
            if (mem_wdata[0]) begin
                exit_valid <= 1'b1;
                exit_code  <= mem_wdata[31:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_rdata <= '0;
        end else if (rd_req) begin
            mem_rdata <= rd_value;
        end
    end

    // Exit is tested ahead of the limit so a coincident exit wins over expiry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_state <= WD_RUN;
            wd_count <= '0;
            timeout  <= 1'b0;
        end else begin
            case (wd_state)
                WD_RUN: begin
                    if (exit_set) begin
                        wd_state <= WD_EXITED;
                    end else if ((TIMEOUT_CYCLES != 0) && (wd_count == WD_LIMIT)) begin
                        wd_state <= WD_EXPIRED;
                        timeout  <= 1'b1;
                    end else begin
                        wd_count <= wd_count + 32'd1;
                    end
                end
                WD_EXITED:  wd_state <= WD_EXITED;
                WD_EXPIRED: wd_state <= WD_EXPIRED;
                default:    wd_state <= WD_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_host_io.sv
// Directed bench for host_io: console FIFO ordering/overflow, tohost exit,
// halt, watchdog expiry and asynchronous reset.
module tb_host_io;

    localparam logic [31:0] CON_A  = 32'h1000_0000;
    localparam logic [31:0] STAT_A = 32'h1000_0004;
    localparam logic [31:0] TH_A   = 32'h1000_1000;
    localparam logic [31:0] LTH_A  = 32'h0000_1000;

    logic        clk;
    logic        rstn;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        exit_valid;
    logic [30:0] exit_code;
    logic        timeout;
    logic        halt;

    int checks = 0;
    int errors = 0;

    host_io #(
        .CONSOLE_ADDR       (CON_A),
        .TOHOST_ADDR        (TH_A),
        .LEGACY_TOHOST_ADDR (LTH_A),
        .FIFO_DEPTH         (16),
        .TIMEOUT_CYCLES     (100)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem_valid  (mem_valid),
        .mem_write  (mem_write),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .con_valid  (con_valid),
        .con_data   (con_data),
        .con_ready  (con_ready),
        .exit_valid (exit_valid),
        .exit_code  (exit_code),
        .timeout    (timeout),
        .halt       (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        tick();
        mem_valid = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_valid = 1'b1;
        mem_write = 1'b0;
        mem_addr  = a;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_wmask = 4'h0;
        mem_wdata = '0;
        mem_addr  = '0;
        con_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q [16];

        // Reset values
        do_reset();
        chk("rst_con_valid", 32'(con_valid), 32'd0);
        chk("rst_con_data", 32'(con_data), 32'd0);
        chk("rst_exit_valid", 32'(exit_valid), 32'd0);
        chk("rst_exit_code", 32'(exit_code), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);

        // Byte lane 0 disabled: no push
        bus_write(CON_A, 32'h0000_0041, 4'b1110);
        chk("wmask0_ignored", 32'(con_valid), 32'd0);

        // 'A','B','C' streamed with con_ready=1
        con_ready = 1'b1;
        bus_write(CON_A, 32'h0000_0041, 4'h1);
        chk("abc_valid", 32'(con_valid), 32'd1);
        chk("abc_a", 32'(con_data), 32'h41);
        bus_write(CON_A, 32'h0000_0042, 4'h1);
        chk("abc_b", 32'(con_data), 32'h42);
        bus_write(CON_A, 32'h0000_0043, 4'h1);
        chk("abc_c", 32'(con_data), 32'h43);
        tick();
        chk("abc_drained", 32'(con_valid), 32'd0);

        // Overflow: 18 pushes into 16 entries
        do_reset();
        for (int i = 0; i < 18; i++) bus_write(CON_A, 32'(8'h10 + i), 4'h1);
        bus_read(STAT_A);
        chk("ovf_status", mem_rdata, 32'h0002_0110);
        chk("ovf_head_stable", 32'(con_data), 32'h10);

        // Push and pop together while full
        con_ready = 1'b1;
        bus_write(CON_A, 32'h0000_00EE, 4'h1);
        con_ready = 1'b0;
        bus_read(STAT_A);
        chk("full_pushpop_status", mem_rdata, 32'h0002_0110);
        for (int i = 0; i < 15; i++) exp_q[i] = 8'(8'h11 + i);
        exp_q[15] = 8'hEE;
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(con_data), 32'(exp_q[i]));
            tick();
        end
        chk("drain_empty", 32'(con_valid), 32'd0);

        // Exit through the legacy alias
        do_reset();
        bus_write(LTH_A, 32'h0000_0055, 4'h1);
        chk("exit_valid", 32'(exit_valid), 32'd1);
        chk("exit_code", 32'(exit_code), 32'h2A);
        chk("exit_halt", 32'(halt), 32'd1);
        bus_read(TH_A);
        chk("tohost_read", mem_rdata, 32'h0000_0055);
        tick();
        chk("rdata_hold", mem_rdata, 32'h0000_0055);
        bus_write(TH_A, 32'h0000_0077, 4'h1);
        bus_read(LTH_A);
        chk("tohost_locked", mem_rdata, 32'h0000_0055);
        chk("exit_code_locked", 32'(exit_code), 32'h2A);
        bus_read(32'h1234_5678);
        chk("other_addr_zero", mem_rdata, 32'h0);
        repeat (110) tick();
        chk("exited_no_timeout", 32'(timeout), 32'd0);

        // halt waits for the console to drain
        do_reset();
        bus_write(CON_A, 32'h31, 4'h1);
        bus_write(CON_A, 32'h32, 4'h1);
        bus_write(TH_A, 32'h0000_0001, 4'h1);
        chk("halt_exit", 32'(exit_valid), 32'd1);
        chk("halt_pending", 32'(halt), 32'd0);
        bus_write(CON_A, 32'h33, 4'h1);
        bus_read(STAT_A);
        chk("halt_level3", mem_rdata, 32'h0000_0003);
        con_ready = 1'b1;
        chk("halt_head", 32'(con_data), 32'h31);
        tick();
        chk("halt_lvl2", 32'(halt), 32'd0);
        tick();
        chk("halt_lvl1", 32'(halt), 32'd0);
        chk("halt_last_byte", 32'(con_data), 32'h33);
        tick();
        chk("halt_set", 32'(halt), 32'd1);

        // Watchdog expiry at cycle 100
        do_reset();
        repeat (99) tick();
        chk("wd_before", 32'(timeout), 32'd0);
        tick();
        chk("wd_expired", 32'(timeout), 32'd1);
        bus_read(STAT_A);
        chk("wd_status", mem_rdata, 32'h0000_0200);

        // Async reset mid-drain
        con_ready = 1'b0;
        bus_write(CON_A, 32'h61, 4'h1);
        bus_write(CON_A, 32'h62, 4'h1);
        bus_write(CON_A, 32'h63, 4'h1);
        bus_write(TH_A, 32'h0000_0003, 4'h1);
        bus_read(TH_A);
        con_ready = 1'b1;
        tick();
        chk("mid_valid", 32'(con_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_con_valid", 32'(con_valid), 32'd0);
        chk("arst_con_data", 32'(con_data), 32'd0);
        chk("arst_exit_valid", 32'(exit_valid), 32'd0);
        chk("arst_exit_code", 32'(exit_code), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        chk("arst_halt", 32'(halt), 32'd0);
        chk("arst_rdata", mem_rdata, 32'd0);
        tick();
        chk("arst_no_byte", 32'(con_valid), 32'd0);

        // Exit coinciding with expiry
        do_reset();
        repeat (99) tick();
        chk("tie_pre", 32'(timeout), 32'd0);
        bus_write(TH_A, 32'h0000_0005, 4'h1);
        chk("tie_exit", 32'(exit_valid), 32'd1);
        chk("tie_code", 32'(exit_code), 32'h2);
        chk("tie_timeout", 32'(timeout), 32'd0);
        repeat (5) tick();
        chk("tie_timeout_later", 32'(timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
